count_gate_readout: RTL and testbench
=====================================

// Module: count_gate_readout
// PURPOSE
//  Measurement controller wrapped around the 16-channel pulse counter array.
//  - Opens a programmable gate window by driving en_count to the counters.
//  - After the gate closes, snapshots all channel counts into a holding bank.
//  - Streams the snapshot out one channel per beat on a valid/ready interface to the host-side packer.
// PARAMETERS
//  NUM_CH      16  number of counter channels
//  CNT_W       16  width of each channel count
//  GATE_W      32  width of the gate-length operand
//  SETTLE_CYC  2   wait cycles between gate close and snapshot; must be >=1
// PORTS
//  clk       in   1             system clock
//  rst       in   1             asynchronous active-low reset
//  start     in   1             one-cycle request to begin a measurement
//  gate_len  in   GATE_W        gate length in clk cycles; sampled when start is accepted
//  cnt_in    in   NUM_CH*CNT_W  flattened counter outputs; channel i at [i*CNT_W +: CNT_W]
//  en_count  out  1             counter enable; high for the whole gate window
//  cnt_clr   out  1             one-cycle clear pulse to the counters
//  busy      out  1             high in every state except IDLE
//  m_valid   out  1             output beat valid
//  m_ready   in   1             downstream accepts the beat
//  m_chan    out  $clog2(NUM_CH)+1  channel index of the current beat
//  m_data    out  CNT_W         count value of the current beat
//  m_last    out  1             marks the final beat of a frame
//  done      out  1             one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  - All outputs are registered.
//  - On reset (rst=0): FSM goes to IDLE; all outputs are 0; the snapshot bank is 0.
//  - Reset mid-operation aborts immediately; no partial frame is completed.
//  - FSM: IDLE -> CLR -> GATE -> SETTLE -> SNAP -> SEND -> IDLE.
//    - IDLE: start=1 at edge k latches gate_len into gcnt and moves to CLR.
//    - CLR (cycle k+1): cnt_clr=1. Next state is GATE, or SETTLE if the latched gate_len==0.
//    - GATE: en_count=1 for exactly gate_len cycles (k+2 .. k+1+gate_len), then SETTLE.
//      - gate_len = 2^GATE_W-1 is legal; no wrap.
//    - SETTLE: en_count=0 for SETTLE_CYC cycles; covers the counter output register.
//    - SNAP: one cycle; latches all NUM_CH counts from cnt_in into the bank.
//    - SEND: beat n carries m_chan=n, m_data=bank[n], for n = 0..NUM_CH-1.
//  - start while busy=1 is ignored: not queued, no effect.
//  - Handshake:
//    - A beat transfers on m_valid & m_ready at a clock edge.
//    - m_valid does not depend on m_ready.
//    - Once m_valid=1, m_chan/m_data/m_last hold stable until the transfer.
//    - Back-to-back beats at 1 per cycle when m_ready stays high.
//  - Timing:
//    - First m_valid is asserted the cycle after SNAP.
//    - m_valid=1 at cycle k+3+gate_len+SETTLE_CYC, with SETTLE_CYC wait cycles starting at k+2+gate_len.
//    - m_last=1 only on the final beat.
//    - done pulses the cycle after the final transfer; busy falls in that same cycle.
//  - cnt_in changes after SNAP do not affect the streamed data.
// CONFIGURATION
//  CNT_READOUT_CKSUM_EN defined:
//    - After channel NUM_CH-1, one extra beat is sent with m_chan=NUM_CH and m_data = XOR of all bank entries.
//    - m_last is set on this extra beat only.
//  CNT_READOUT_CKSUM_EN undefined:
//    - NUM_CH beats per frame; m_last is on channel NUM_CH-1.
//    - m_chan never equals NUM_CH.
// TESTING
//  1. Reset: hold rst=0 with random inputs -> every output is 0. Assert rst=0 during SEND -> m_valid=0 immediately, busy=0.
//  2. Gate timing: gate_len=5, start at edge 10 -> cnt_clr=1 in cycle 11 only; en_count=1 in cycles 12..16 only.
//  3. Readout: cnt_in[i]=16'h0100+i, m_ready=1 ->
//     - 16 consecutive beats with m_chan 0..15 and m_data 0x0100..0x010F;
//     - m_last on chan 15; done 1 cycle later.
//  4. Backpressure: toggle m_ready randomly -> no beat lost or duplicated; data stable while m_valid & !m_ready.
//     - Change cnt_in after SNAP -> streamed values are unchanged.
//  5. Edge cases:
//     - gate_len=0 -> en_count never high; the frame is still sent.
//     - start pulsed during GATE -> ignored; only one frame is produced.
//  6. With CNT_READOUT_CKSUM_EN, counts from test 3 -> 17th beat has m_chan=16, m_data=16'h0000, m_last=1.

Source files
------------

// File: rtl/count_gate_readout.sv
// rtl/count_gate_readout.sv - gated measurement controller with snapshot readout stream
//
// Purpose: opens a programmable counting gate on the pulse counter array,
// waits for the counter outputs to settle, snapshots every channel into a
// holding bank and streams the bank out one channel per valid/ready beat.
//
// Optional feature macro: CNT_READOUT_CKSUM_EN
//   defined   - one extra beat (m_chan = NUM_CH, m_data = XOR of bank) ends the frame
//   undefined - NUM_CH beats per frame, m_last on channel NUM_CH-1
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     one-cycle measurement request (ignored while busy)
//   gate_len  gate length in clk cycles, sampled with start
//   cnt_in    flattened counter outputs, channel i at [i*CNT_W +: CNT_W]
//   en_count  counter enable, high for the gate window
//   cnt_clr   one-cycle counter clear pulse
//   busy      high whenever the controller is not idle
//   m_valid / m_ready / m_chan / m_data / m_last  readout stream
//   done      one-cycle pulse after the final beat transfers

module count_gate_readout #(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [GATE_W-1:0]         gate_len,
  input  logic [NUM_CH*CNT_W-1:0]   cnt_in,
  output logic                      en_count,
  output logic                      cnt_clr,
  output logic                      busy,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(NUM_CH):0]   m_chan,
  output logic [CNT_W-1:0]          m_data,
  output logic                      m_last,
  output logic                      done
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SC_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE_CYC - 1);

`ifdef CNT_READOUT_CKSUM_EN
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH);
`else
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GATE,
    S_SETTLE,
    S_SNAP,
    S_SEND
  } state_t;

  state_t             state;
  logic [GATE_W-1:0]  gcnt;
  logic [SC_W-1:0]    scnt;
  logic [CNT_W-1:0]   bank [NUM_CH];

  // Index of the channel after the current one; only meaningful while a
  // data channel (not the checksum beat) is on the bus.
  logic [IDX_W-1:0]   next_idx;
  logic [CNT_W-1:0]   next_data;

  assign next_idx = m_chan[IDX_W-1:0] + 1'b1;

`ifdef CNT_READOUT_CKSUM_EN
  logic [CNT_W-1:0]   cksum;

  always_comb begin
    cksum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cksum = cksum ^ bank[i];
    end
  end

  always_comb begin
    next_data = bank[next_idx];
    if (m_chan == CH_W'(NUM_CH - 1)) begin
      next_data = cksum;
    end
  end
`else
  always_comb begin
    next_data = bank[next_idx];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gcnt     <= '0;
      scnt     <= '0;
      en_count <= 1'b0;
      cnt_clr  <= 1'b0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m_chan   <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            gcnt    <= gate_len;
            cnt_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= S_CLR;
          end
        end
        S_CLR: begin
          if (gcnt == '0) begin
            scnt  <= SC_INIT;
            state <= S_SETTLE;
          end else begin
            en_count <= 1'b1;
            state    <= S_GATE;
          end
        end
        S_GATE: begin
          // Down-count ends at 1 so the maximum gate length never wraps.
          if (gcnt == GATE_W'(1)) begin
            en_count <= 1'b0;
            scnt     <= SC_INIT;
            state    <= S_SETTLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (scnt == '0) begin
            state <= S_SNAP;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        S_SNAP: begin
          for (int i = 0; i < NUM_CH; i++) begin
            bank[i] <= cnt_in[i*CNT_W +: CNT_W];
          end
          // First beat comes straight from cnt_in: the bank is written on this same edge.
          m_valid <= 1'b1;
          m_chan  <= '0;
          m_data  <= cnt_in[CNT_W-1:0];
          m_last  <= (LAST_CH == '0);
          state   <= S_SEND;
        end
        S_SEND: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_chan  <= '0;
              m_data  <= '0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              m_chan <= m_chan + 1'b1;
              m_data <= next_data;
              m_last <= ((m_chan + 1'b1) == LAST_CH);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_gate_readout.sv
// tb/tb_count_gate_readout.sv - directed self-checking bench for count_gate_readout

module tb_count_gate_readout;

`ifdef CNT_READOUT_CKSUM_EN
  localparam int NFRAME = 17;
`else
  localparam int NFRAME = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   gate_len;
  logic [255:0]  cnt_in;
  logic          en_count;
  logic          cnt_clr;
  logic          busy;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    m_chan;
  logic [15:0]   m_data;
  logic          m_last;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  count_gate_readout dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .gate_len (gate_len),
    .cnt_in   (cnt_in),
    .en_count (en_count),
    .cnt_clr  (cnt_clr),
    .busy     (busy),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_chan   (m_chan),
    .m_data   (m_data),
    .m_last   (m_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_counts(input logic [15:0] base, input logic [15:0] stp);
    for (int i = 0; i < 16; i++) begin
      cnt_in[i*16 +: 16] = base + 16'(i) * stp;
    end
  endtask

  // Returns positioned in cycle k+1 (the CLR cycle).
  task automatic pulse_start(input logic [31:0] gl);
    gate_len = gl;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      start    = 1'($urandom);
      gate_len = $urandom;
      m_ready  = 1'($urandom);
      for (int i = 0; i < 8; i++) cnt_in[i*32 +: 32] = $urandom;
      step();
      obs = {en_count, cnt_clr, busy, m_valid, m_chan, m_data, m_last, done};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
      end
    end
    start   = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b m_valid=%b expected 0 0", busy, m_valid);
    end
  endtask

  task automatic test_gate_timing();
    bit ok;
    m_ready = 1'b0;
    pulse_start(32'd5);
    for (int c = 1; c <= 12; c++) begin
      n_cmp++;
      if (cnt_clr !== (c == 1) || en_count !== (c >= 2 && c <= 6) ||
          busy !== 1'b1 || m_valid !== (c >= 10)) begin
        n_bad++;
        $display("FAIL gate_timing cycle k+%0d: clr=%b en=%b busy=%b valid=%b expected %b %b 1 %b",
                 c, cnt_clr, en_count, busy, m_valid, c == 1, c >= 2 && c <= 6, c >= 10);
      end
      step();
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL gate_timing_drain: done got 0 expected 1");
    end
    m_ready = 1'b0;
  endtask

  task automatic test_readout();
    bit ok;
    logic [15:0] ed;
    set_counts(16'h0100, 16'h0001);
    m_ready = 1'b1;
    pulse_start(32'd3);
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL readout_valid: m_valid got 0 expected 1");
    end
    for (int n = 0; n < NFRAME; n++) begin
      ed = (n < 16) ? 16'h0100 + 16'(n) : 16'h0000;
      n_cmp++;
      if (m_valid !== 1'b1 || m_chan !== 5'(n) || m_data !== ed ||
          m_last !== (n == NFRAME - 1) || done !== 1'b0) begin
        n_bad++;
        $display("FAIL readout_beat %0d: v=%b chan=%0d data=%h last=%b done=%b expected 1 %0d %h %b 0",
                 n, m_valid, m_chan, m_data, m_last, done, n, ed, n == NFRAME - 1);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL readout_done: done=%b busy=%b valid=%b expected 1 0 0", done, busy, m_valid);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL readout_done_pulse: done got %b expected 0", done);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit fin;
    int beats;
    logic [15:0] exp_d [NFRAME];
    logic [15:0] x;
    bit hold;
    logic [4:0] h_chan;
    logic [15:0] h_data;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = 16'hA000 + 16'(i) * 16'h0111;
      x = x ^ exp_d[i];
    end
    if (NFRAME > 16) exp_d[NFRAME-1] = x;
    set_counts(16'hA000, 16'h0111);
    m_ready = 1'b0;
    pulse_start(32'd2);
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_valid: m_valid got 0 expected 1");
    end
    set_counts(16'h5555, 16'h0003);
    beats = 0;
    fin   = 1'b0;
    hold  = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (hold) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_chan !== h_chan || m_data !== h_data) begin
          n_bad++;
          $display("FAIL bp_hold: v=%b chan=%0d data=%h expected 1 %0d %h", m_valid, m_chan, m_data, h_chan, h_data);
        end
      end
      hold   = m_valid && !m_ready;
      h_chan = m_chan;
      h_data = m_data;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (beats >= NFRAME || m_chan !== 5'(beats) || m_data !== exp_d[beats] ||
            m_last !== (beats == NFRAME - 1)) begin
          n_bad++;
          $display("FAIL bp_beat %0d: chan=%0d data=%h last=%b", beats, m_chan, m_data, m_last);
        end
        beats++;
      end
      step();
      if (done) fin = 1'b1;
    end
    n_cmp++;
    if (!fin || beats != NFRAME) begin
      n_bad++;
      $display("FAIL bp_count: beats=%0d done=%b expected %0d 1", beats, fin, NFRAME);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_gate_zero();
    bit en_seen;
    bit fin;
    int beats;
    int first_v;
    set_counts(16'h0100, 16'h0001);
    m_ready = 1'b1;
    pulse_start(32'd0);
    en_seen = 1'b0;
    fin     = 1'b0;
    beats   = 0;
    first_v = -1;
    for (int c = 1; c < 80 && !fin; c++) begin
      if (en_count) en_seen = 1'b1;
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) beats++;
      step();
      if (done) fin = 1'b1;
    end
    n_cmp++;
    if (en_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_zero_en: en_count seen=%b expected 0", en_seen);
    end
    n_cmp++;
    if (first_v != 5) begin
      n_bad++;
      $display("FAIL gate_zero_latency: first valid at k+%0d expected k+5", first_v);
    end
    n_cmp++;
    if (!fin || beats != NFRAME) begin
      n_bad++;
      $display("FAIL gate_zero_frame: beats=%0d done=%b expected %0d 1", beats, fin, NFRAME);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    int en_cyc;
    int beats;
    int dones;
    bit late_valid;
    m_ready = 1'b1;
    pulse_start(32'd8);
    en_cyc     = 0;
    beats      = 0;
    dones      = 0;
    late_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      start = (c == 4);
      if (en_count) en_cyc++;
      if (m_valid && m_ready) beats++;
      if (done) dones++;
      if (c > 40 && (m_valid || busy)) late_valid = 1'b1;
      step();
    end
    start = 1'b0;
    n_cmp++;
    if (en_cyc != 8) begin
      n_bad++;
      $display("FAIL ignore_en_cycles: got %0d expected 8", en_cyc);
    end
    n_cmp++;
    if (beats != NFRAME || dones != 1 || late_valid) begin
      n_bad++;
      $display("FAIL ignore_frames: beats=%0d dones=%0d late=%b expected %0d 1 0", beats, dones, late_valid, NFRAME);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    m_ready = 1'b0;
    pulse_start(32'd1);
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midrst_valid: m_valid got 0 expected 1");
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_chan !== 5'd0 || m_data !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_abort: v=%b busy=%b chan=%0d data=%h expected 0 0 0 0", m_valid, busy, m_chan, m_data);
    end
    step();
    rst     = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
    end
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: v=%b busy=%b done=%b expected 0 0 0", m_valid, busy, done);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    gate_len = '0;
    cnt_in   = '0;
    m_ready  = 1'b0;
    step();
    test_reset();
    test_gate_timing();
    test_readout();
    test_backpressure();
    test_gate_zero();
    test_start_ignored();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
